// File: rtl/led_ring_decoder.sv
// Decodes a rotating 12-bit LED ring pattern into a phase index and tracks
// rotation lock via a HUNT/TRACK/LOCKED state machine.
module led_ring_decoder #(
  parameter logic [11:0] BASE_PATTERN  = 12'b000011101101,
  parameter int unsigned STABLE_CYCLES = 4,
  parameter int unsigned LOCK_COUNT    = 3,
  parameter int unsigned MISS_LIMIT    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [11:0] pat_in,
  output logic [3:0]  phase,
  output logic        phase_valid,
  output logic        locked,
  output logic        step_pulse,
  output logic        err_pulse,
  output logic [7:0]  err_count
);

  localparam logic [1:0] StHunt   = 2'd0;
  localparam logic [1:0] StTrack  = 2'd1;
  localparam logic [1:0] StLocked = 2'd2;

  localparam logic [3:0] StableMax = 4'(STABLE_CYCLES);
  localparam logic [3:0] StableM1  = 4'(STABLE_CYCLES - 1);
  localparam logic [3:0] LockMax   = 4'(LOCK_COUNT);
  localparam logic [3:0] MissMax   = 4'(MISS_LIMIT);

  function automatic logic [11:0] rotl(input logic [11:0] v, input int k);
    logic [11:0] r;
    r = v;
    for (int i = 0; i < 12; i++) begin
      if (i < k) r = {r[10:0], r[11]};
    end
    return r;
  endfunction

  // Synchronizer and stability tracking
  logic [11:0] meta_q, sync_q, prev_q;
  logic [3:0]  stab_q, stab_d;
  logic [11:0] last_acc_q;
  logic        last_acc_vld_q;
  logic        changed, accept;

  assign changed = (sync_q != prev_q);
  // Accept on the cycle the counter would first hit its limit; a pattern identical to the
  // last accepted one (e.g. the return after a short glitch) is never accepted again.
  assign accept  = !changed && (stab_q == StableM1) &&
                   !(last_acc_vld_q && (sync_q == last_acc_q));

  always_comb begin
    stab_d = stab_q;
    if (changed) begin
      stab_d = 4'd0;
    end else if (stab_q < StableMax) begin
      stab_d = stab_q + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q         <= '0;
      sync_q         <= '0;
      prev_q         <= '0;
      stab_q         <= '0;
      last_acc_q     <= '0;
      last_acc_vld_q <= 1'b0;
    end else begin
      meta_q <= pat_in;
      sync_q <= meta_q;
      prev_q <= sync_q;
      stab_q <= stab_d;
      if (accept) begin
        last_acc_q     <= sync_q;
        last_acc_vld_q <= 1'b1;
      end
    end
  end

  // Rotation decode; descending scan so the lowest matching k wins
  logic       dec_hit;
  logic [3:0] dec_idx;

  always_comb begin
    dec_hit = 1'b0;
    dec_idx = 4'd0;
    for (int k = 11; k >= 0; k--) begin
      if (sync_q == rotl(BASE_PATTERN, k)) begin
        dec_hit = 1'b1;
        dec_idx = 4'(k);
      end
    end
  end

  // Tracking state machine
  logic [1:0] state_q, state_d;
  logic [3:0] good_q, good_d;
  logic [3:0] miss_q, miss_d;
  logic [3:0] phase_q, phase_d;
  logic       valid_q, valid_d;
  logic       locked_q, step_q, step_d, err_q, err_d;
  logic [7:0] err_cnt_q, err_cnt_d;
  logic [3:0] exp_phase;
  logic       is_expected;

  assign exp_phase   = (phase_q == 4'd11) ? 4'd0 : phase_q + 4'd1;
  assign is_expected = dec_hit && (dec_idx == exp_phase);

  always_comb begin
    state_d   = state_q;
    good_d    = good_q;
    miss_d    = miss_q;
    phase_d   = phase_q;
    valid_d   = valid_q;
    step_d    = 1'b0;
    err_d     = 1'b0;
    err_cnt_d = err_cnt_q;

    if (accept) begin
      valid_d = dec_hit;
      if (dec_hit) phase_d = dec_idx;

      case (state_q)
        StHunt: begin
          if (dec_hit) begin
            good_d  = 4'd1;
            miss_d  = 4'd0;
            state_d = (LockMax == 4'd1) ? StLocked : StTrack;
          end
        end
        StTrack: begin
          if (!dec_hit) begin
            state_d = StHunt;
            good_d  = 4'd0;
          end else if (is_expected) begin
            // Lock on the LOCK_COUNT-th correct step after the anchoring accept
            if (good_q >= LockMax) begin
              state_d = StLocked;
              miss_d  = 4'd0;
            end else begin
              good_d = good_q + 4'd1;
            end
          end else begin
            good_d = 4'd1;
          end
        end
        StLocked: begin
          if (is_expected) begin
            step_d = 1'b1;
            miss_d = 4'd0;
          end else begin
            err_d = 1'b1;
            if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
            if (miss_q + 4'd1 >= MissMax) begin
              state_d = StHunt;
              miss_d  = 4'd0;
              good_d  = 4'd0;
            end else begin
              miss_d = miss_q + 4'd1;
            end
          end
        end
        default: begin
          state_d = StHunt;
          good_d  = 4'd0;
          miss_d  = 4'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StHunt;
      good_q    <= '0;
      miss_q    <= '0;
      phase_q   <= '0;
      valid_q   <= 1'b0;
      locked_q  <= 1'b0;
      step_q    <= 1'b0;
      err_q     <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      good_q    <= good_d;
      miss_q    <= miss_d;
      phase_q   <= phase_d;
      valid_q   <= valid_d;
      locked_q  <= (state_d == StLocked);
      step_q    <= step_d;
      err_q     <= err_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign phase       = phase_q;
  assign phase_valid = valid_q;
  assign locked      = locked_q;
  assign step_pulse  = step_q;
  assign err_pulse   = err_q;
  assign err_count   = err_cnt_q;

endmodule
